// File: rtl/bypass_scoreboard.sv
// Operand bypass and RAW/WAW hazard block with a long-latency destination scoreboard.
// Latency: forwarding and stall are combinational; scoreboard, LONG_FULL and SB_ERR update one edge later.
// Backpressure: stall holds ID/IF; issue while full is dropped and flagged. Optional macro: BYPASS_SB_STALL_CNT_EN.
module bypass_scoreboard #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int NUM_READ   = 2,
   parameter int MAX_LONG   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_READ*REG_ADDR_W-1:0] rs_addr,
   input  logic [NUM_READ-1:0]            rs_valid,
   input  logic [NUM_READ*XLEN-1:0]       rf_data,
   input  logic [REG_ADDR_W-1:0]          id_rd,
   input  logic                           id_rd_valid,
   input  logic [REG_ADDR_W-1:0]          ex_rd,
   input  logic                           ex_we,
   input  logic                           ex_ready,
   input  logic [XLEN-1:0]                ex_data,
   input  logic [REG_ADDR_W-1:0]          mem_rd,
   input  logic                           mem_we,
   input  logic                           mem_ready,
   input  logic [XLEN-1:0]                mem_data,
   input  logic [REG_ADDR_W-1:0]          wb_rd,
   input  logic                           wb_we,
   input  logic [XLEN-1:0]                wb_data,
   input  logic                           long_issue,
   input  logic [REG_ADDR_W-1:0]          long_rd,
   input  logic                           long_done,
   input  logic [REG_ADDR_W-1:0]          long_done_rd,
   input  logic [XLEN-1:0]                long_done_data,
   output logic [NUM_READ*XLEN-1:0]       fwd_data,
   output logic                           stall,
   output logic                           long_full,
   output logic                           sb_err,
   output logic [31:0]                    stall_cnt
);

   localparam int NREG = 1 << REG_ADDR_W;
   localparam int CW   = $clog2(MAX_LONG + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LONG);

   logic [NREG-1:0]     pending;
   logic [CW-1:0]       count;
   logic [NUM_READ-1:0] port_hz;

   assign long_full = (count == MAX_CNT);

   for (genvar i = 0; i < NUM_READ; i++) begin : g_port
      logic [REG_ADDR_W-1:0] a;
      logic [XLEN-1:0]       d;
      logic                  h;
      assign a = rs_addr[i*REG_ADDR_W +: REG_ADDR_W];

      // First match wins, newest producer first; a hazard leaves the RF value on the bus.
      always_comb begin
         d = rf_data[i*XLEN +: XLEN];
         h = 1'b0;
         if (a == '0) begin
            d = '0;
         end else if (ex_we && ex_rd == a) begin
            if (ex_ready) d = ex_data;
            else          h = 1'b1;
         end else if (mem_we && mem_rd == a) begin
            if (mem_ready) d = mem_data;
            else           h = 1'b1;
         end else if (long_done && long_done_rd == a) begin
            d = long_done_data;
         end else if (pending[a] || (long_issue && long_rd == a)) begin
            h = 1'b1;
         end else if (wb_we && wb_rd == a) begin
            d = wb_data;
         end
      end

      assign port_hz[i] = h & rs_valid[i];
      assign fwd_data[i*XLEN +: XLEN] = d;
   end

   logic done_nz, done_ok, issue_nz, issue_dup, issue_ok, waw;

   assign done_nz   = long_done && (long_done_rd != '0);
   assign done_ok   = done_nz && pending[long_done_rd];
   assign issue_nz  = long_issue && (long_rd != '0);
   // A register being retired this same edge may be legally re-claimed.
   assign issue_dup = issue_nz && pending[long_rd] && !(done_ok && long_done_rd == long_rd);
   assign issue_ok  = issue_nz && !issue_dup && !(long_full && !done_ok);

   assign waw   = id_rd_valid && (id_rd != '0) && pending[id_rd]
                  && !(long_done && long_done_rd == id_rd);
   assign stall = (|port_hz) || waw || (long_full && id_rd_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         count   <= '0;
         sb_err  <= 1'b0;
      end else begin
         logic [NREG-1:0] p;
         p = pending;
         if (done_ok)  p[long_done_rd] = 1'b0;
         if (issue_ok) p[long_rd]      = 1'b1;
         pending <= p;
         count   <= count + CW'(issue_ok) - CW'(done_ok);
         if ((done_nz && !done_ok) || (issue_nz && !issue_ok))
            sb_err <= 1'b1;
      end
   end

`ifdef BYPASS_SB_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        stall_cnt <= '0;
      else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/bypass_scoreboard.md
# bypass_scoreboard

Parametrised operand-bypass and hazard block for the RISC-V integer pipeline, sitting between decode (ID) and the EX/MEM/WB stages. It selects the newest value of each ID source operand from EX, MEM, long-latency completion, WB or the register file, and raises a stall for unresolved RAW and WAW hazards. A registered scoreboard tracks destination registers owned by in-flight long-latency operations (divider, multi-cycle multiply) with a bounded outstanding count. A sticky protocol-error flag records misuse of the scoreboard interface.

## Interface
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register address width (2^REG_ADDR_W architectural registers)
- NUM_READ, 2, number of ID source-operand ports
- MAX_LONG, 4, maximum outstanding long-latency operations (1..2^REG_ADDR_W-1)

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- RS_ADDR  in  NUM_READ*REG_ADDR_W  ID source addresses, port i at [i*REG_ADDR_W +: REG_ADDR_W]
- RS_VALID  in  NUM_READ  per-port operand used
- RF_DATA  in  NUM_READ*XLEN  register-file read data
- ID_RD, ID_RD_VALID  in  REG_ADDR_W, 1  ID destination (WAW check)
- EX_RD, EX_WE, EX_READY, EX_DATA  in  REG_ADDR_W, 1, 1, XLEN  EX result; READY=0 means data not yet produced (load, long op)
- MEM_RD, MEM_WE, MEM_READY, MEM_DATA  in  same  MEM result; READY=0 means pending (cache miss)
- WB_RD, WB_WE, WB_DATA  in  REG_ADDR_W, 1, XLEN  write-back
- LONG_ISSUE, LONG_RD  in  1, REG_ADDR_W  long op leaves EX, claims LONG_RD
- LONG_DONE, LONG_DONE_RD, LONG_DONE_DATA  in  1, REG_ADDR_W, XLEN  long op completes
- FWD_DATA  out  NUM_READ*XLEN  resolved operands
- STALL  out  1  hold ID/IF this cycle
- LONG_FULL  out  1  outstanding count == MAX_LONG
- SB_ERR  out  1  sticky protocol error
- STALL_CNT  out  32  stall-cycle counter (see Configuration)

## Operation
- State: pending[2^REG_ADDR_W] bits, count[clog2(MAX_LONG+1)], SB_ERR, STALL_CNT.
- x0: writes to register 0 are never tracked or forwarded; a port reading x0 yields 0 and never stalls.
- Per port i, priority newest first: EX match (EX_WE, addr equal, nonzero) -> EX_DATA if EX_READY else hazard; MEM match -> MEM_DATA if MEM_READY else hazard; LONG_DONE match -> LONG_DONE_DATA; pending[addr] or (LONG_ISSUE and LONG_RD==addr) -> hazard; WB match -> WB_DATA; else RF_DATA. First match decides; hazard still drives RF_DATA on FWD_DATA.
- Ports with RS_VALID=0 never cause hazards.
- STALL = any port hazard OR (ID_RD_VALID, ID_RD nonzero, pending[ID_RD] not cleared by LONG_DONE this cycle) OR (LONG_FULL and ID_RD_VALID).
- Scoreboard update each edge: LONG_DONE clears pending[LONG_DONE_RD]; LONG_ISSUE sets pending[LONG_RD]; same register both -> set wins. count += ISSUE - DONE.
- Errors (set SB_ERR, sticky until reset): LONG_DONE with pending[LONG_DONE_RD]=0 (clear ignored, count unchanged); LONG_ISSUE with count==MAX_LONG and no simultaneous valid DONE (issue ignored); LONG_ISSUE to an already pending register (bit stays set, count unchanged).
- LONG_ISSUE or LONG_DONE with rd=0: ignored, no error.

## Timing
- FWD_DATA, STALL: combinational, zero latency from inputs and current state.
- Issue in cycle N: hazard visible in N (combinational term), pending bit from N+1.
- Done in cycle N: forwarded in N; pending clear from N+1.
- LONG_FULL registered-state derived; updates the cycle after the change.
- Reset (asserted any time, async): pending=0, count=0, SB_ERR=0, STALL_CNT=0, LONG_FULL=0; with all valid/enable inputs low STALL=0 and FWD_DATA=RF_DATA. Mid-operation reset discards all outstanding ownership.

## Configuration
- BYPASS_SB_STALL_CNT_EN defined: STALL_CNT increments by 1 on each edge with STALL=1, saturates at 0xFFFFFFFF, reset to 0.
- Undefined: no counter register; STALL_CNT tied to 0.

## Test plan
- EX_WE=1, EX_RD=5, EX_READY=1, EX_DATA=0xAAAA, MEM writes x5=0xBBBB, RS_ADDR[0]=5 -> FWD_DATA[0]=0xAAAA, STALL=0.
- Load-use: EX_RD=7, EX_READY=0, RS_ADDR[1]=7 -> STALL=1; next cycle MEM_RD=7, MEM_READY=1, MEM_DATA=0x1234 -> STALL=0, FWD_DATA[1]=0x1234.
- LONG_ISSUE rd=9 -> STALL=1 for reader of x9 in issue cycle and each following cycle; LONG_DONE rd=9 data 0x55 -> same cycle FWD=0x55, STALL=0; pending clear next cycle.
- MAX_LONG=4: issue x1..x4 -> LONG_FULL=1; fifth issue -> ignored, SB_ERR=1; issue+done same cycle while full -> count stays 4, no error.
- RS_ADDR=0 with EX writing x0=0xFFFF -> FWD_DATA=0, STALL=0; LONG_DONE rd=3 not pending -> SB_ERR=1.
- With BYPASS_SB_STALL_CNT_EN: 10 stall cycles -> STALL_CNT=10; assert RST_N=0 mid-stall -> all state 0 immediately.
